// File: rtl/minmax_pkg.sv
// Shared types and helpers for the min/max feeder: state encoding, byte type, frame size
// and the averaging function used for the expected result.
package minmax_pkg;

  localparam int NBYTES = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  // The sum needs a ninth bit so that 0xFF + 0xFF averages back to 0xFF.
  function automatic byte_t avg2(input byte_t a, input byte_t b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

endpackage

// File: rtl/minmax_feeder_if.sv
// Host + averaging-unit signal bundle; slave is the feeder's view, master the environment's.
// No handshake: the unit consumes one byte per cycle and answers with a done strobe.
interface minmax_feeder_if;
  import minmax_pkg::*;

  logic       load_en;
  logic [2:0] load_addr;
  byte_t      load_data;
  logic       go;
  logic       busy;
  logic       tx_start;
  byte_t      tx_data;
  byte_t      rx_w;
  logic       rx_done;
  byte_t      avg;
  logic       avg_valid;
  logic       timeout_err;
  logic       mismatch;

  modport slave (
    input  load_en, load_addr, load_data, go, rx_w, rx_done,
    output busy, tx_start, tx_data, avg, avg_valid, timeout_err, mismatch
  );

  modport master (
    output load_en, load_addr, load_data, go, rx_w, rx_done,
    input  busy, tx_start, tx_data, avg, avg_valid, timeout_err, mismatch
  );

endinterface

// File: rtl/minmax_track.sv
// Running min/max over the bytes being transmitted; exp_avg is ready the cycle after the last byte.
// Cleared by the start strobe; no backpressure, follows the transmit stream cycle by cycle.
module minmax_track
  import minmax_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  start,
  input  logic  vld,
  input  byte_t dat,
  output byte_t exp_avg
);

  byte_t lo;
  byte_t hi;

  always_ff @(posedge clock) begin
    if (reset) begin
      lo <= '0;
      hi <= '0;
    end else if (start) begin
      lo <= dat;
      hi <= dat;
    end else if (vld) begin
      if (dat < lo) lo <= dat;
      if (dat > hi) hi <= dat;
    end
  end

  assign exp_avg = avg2(lo, hi);

endmodule

// File: rtl/minmax_feeder.sv
// Frame transmitter for the min/max averaging unit: start + 8 bytes, then waits for done or times out.
// All outputs registered; FEEDER_CHECK_EN adds a self-check of the returned average (mismatch pulse).
module minmax_feeder
  import minmax_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic            clock,
  input logic            reset,
  minmax_feeder_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  byte_t      frame [NBYTES];
  logic [2:0] idx;
  logic [7:0] cnt;
  logic       idle;
  logic       start;
  logic       capture;
  logic       expire;
  byte_t      first_byte;

  // busy stays high through the capture/timeout cycle, so IDLE only counts once it drops.
  always_comb begin
    idle       = (state == IDLE) && !bus.busy;
    start      = idle && bus.go;
    capture    = (state == WAIT) && bus.rx_done;
    expire     = (state == WAIT) && !bus.rx_done && (cnt == LAST_CNT);
    first_byte = (bus.load_en && (bus.load_addr == 3'd0)) ? bus.load_data : frame[0];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (idx == LAST_IDX) state_nxt = WAIT;
      WAIT:    if (capture || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NBYTES; i++) frame[i] <= '0;
    end else if (idle && bus.load_en) begin
      frame[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx             <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.avg         <= '0;
      bus.avg_valid   <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.avg_valid   <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.busy        <= (state_nxt != IDLE) || capture || expire;
      case (state)
        IDLE: begin
          if (start) begin
            idx          <= '0;
            bus.tx_start <= 1'b1;
            bus.tx_data  <= first_byte;
          end
        end
        SEND: begin
          if (idx == LAST_IDX) begin
            cnt <= '0;
          end else begin
            idx         <= idx + 3'd1;
            bus.tx_data <= frame[idx + 3'd1];
          end
        end
        WAIT: begin
          if (capture) begin
            bus.avg       <= bus.rx_w;
            bus.avg_valid <= 1'b1;
          end else if (expire) begin
            bus.timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FEEDER_CHECK_EN
  byte_t exp_avg;

  minmax_track u_track (
    .clock   (clock),
    .reset   (reset),
    .start   (bus.tx_start),
    .vld     (state == SEND),
    .dat     (bus.tx_data),
    .exp_avg (exp_avg)
  );

  always_ff @(posedge clock) begin
    if (reset) bus.mismatch <= 1'b0;
    else       bus.mismatch <= capture && (bus.rx_w != exp_avg);
  end
`else
  assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_minmax_feeder.sv
// Directed bench for minmax_feeder: frame transmit, capture, self-check, timeout, mid-frame reset,
// and ignored host writes while busy. Expected mismatch follows FEEDER_CHECK_EN.
module tb_minmax_feeder;
  import minmax_pkg::*;

`ifdef FEEDER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  minmax_feeder_if bus ();

  minmax_feeder #(.TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  byte_t fa [8] = '{8'd10, 8'd200, 8'd55, 8'd3, 8'd250, 8'd77, 8'd128, 8'd9};
  byte_t ff [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  byte_t fm [8] = '{8'h42, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  byte_t fz [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk8(input string tag, input byte_t obs, input byte_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic load_frame(input byte_t f [8]);
    for (int i = 0; i < 8; i++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 3'(i);
      bus.load_data = f[i];
      tick();
    end
    bus.load_en = 1'b0;
  endtask

  // Caller raises go (and optionally load_en); returns in the first WAIT cycle.
  task automatic send_frame(input byte_t f [8], input logic disturb);
    tick();
    bus.go      = 1'b0;
    bus.load_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("tx_start", bus.tx_start, i == 0);
      chk8("tx_data", bus.tx_data, f[i]);
      chk1("busy_send", bus.busy, 1'b1);
      if (disturb && i == 3) begin
        bus.go        = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 3'd5;
        bus.load_data = 8'h11;
      end else begin
        bus.go      = 1'b0;
        bus.load_en = 1'b0;
      end
      tick();
    end
    chk1("wait_tx_start", bus.tx_start, 1'b0);
    chk8("wait_tx_data", bus.tx_data, 8'h00);
    chk1("wait_busy", bus.busy, 1'b1);
  endtask

  task automatic capture(input byte_t w, input logic mm);
    bus.rx_done = 1'b1;
    bus.rx_w    = w;
    tick();
    bus.rx_done = 1'b0;
    chk8("cap_avg", bus.avg, w);
    chk1("cap_avg_valid", bus.avg_valid, 1'b1);
    chk1("cap_mismatch", bus.mismatch, mm);
    chk1("cap_busy", bus.busy, 1'b1);
    tick();
    chk1("post_avg_valid", bus.avg_valid, 1'b0);
    chk1("post_mismatch", bus.mismatch, 1'b0);
    chk1("post_busy", bus.busy, 1'b0);
    chk8("post_avg_hold", bus.avg, w);
  endtask

  task automatic chk_reset_outputs();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_tx_start", bus.tx_start, 1'b0);
    chk8("rst_tx_data", bus.tx_data, 8'h00);
    chk8("rst_avg", bus.avg, 8'h00);
    chk1("rst_avg_valid", bus.avg_valid, 1'b0);
    chk1("rst_timeout_err", bus.timeout_err, 1'b0);
    chk1("rst_mismatch", bus.mismatch, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_en   = 1'b0;
    bus.load_addr = 3'd0;
    bus.load_data = 8'h00;
    bus.go        = 1'b0;
    bus.rx_w      = 8'h00;
    bus.rx_done   = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outputs();

    // Basic frame, correct result (min 3, max 250 -> 126).
    load_frame(fa);
    bus.go = 1'b1;
    send_frame(fa, 1'b0);
    capture(8'd126, 1'b0);

    // Host writes and go while busy are ignored; wrong result flags mismatch.
    bus.go = 1'b1;
    send_frame(fa, 1'b1);
    bus.go        = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 3'd0;
    bus.load_data = 8'hEE;
    tick();
    bus.go      = 1'b0;
    bus.load_en = 1'b0;
    chk1("wait_no_restart", bus.tx_start, 1'b0);
    capture(8'd127, CHK);

    // Frame buffer untouched by the ignored writes.
    bus.go = 1'b1;
    send_frame(fa, 1'b0);
    capture(8'd126, 1'b0);

    // All 0xFF: no overflow in the average.
    load_frame(ff);
    bus.go = 1'b1;
    send_frame(ff, 1'b0);
    capture(8'd255, 1'b0);

    // Timeout: no done for 16 cycles after WAIT entry.
    bus.go = 1'b1;
    send_frame(ff, 1'b0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk1("to_early", bus.timeout_err, 1'b0);
    end
    tick();
    chk1("to_pulse", bus.timeout_err, 1'b1);
    chk1("to_avg_valid", bus.avg_valid, 1'b0);
    chk8("to_avg_hold", bus.avg, 8'd255);
    chk1("to_busy", bus.busy, 1'b1);
    tick();
    chk1("to_clear", bus.timeout_err, 1'b0);
    chk1("to_busy_drop", bus.busy, 1'b0);

    // load_en and go together: new byte goes out in the same frame ((0x42+0xFF)>>1 = 0xA0).
    bus.load_en   = 1'b1;
    bus.load_addr = 3'd0;
    bus.load_data = 8'h42;
    bus.go        = 1'b1;
    send_frame(fm, 1'b0);
    capture(8'hA0, 1'b0);

    // Reset at the 4th byte of SEND.
    load_frame(fa);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    chk8("pre_reset_byte3", bus.tx_data, 8'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs();
    bus.go = 1'b1;
    send_frame(fz, 1'b0);
    capture(8'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
